imm_encode: RTL and testbench
=============================

IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the saturating range-error counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  request carries valid sel/value/base.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port sel  input  2  immediate field selector.
REQ-007 SHALL have port value  input  16  two's-complement immediate to encode.
REQ-008 SHALL have port base  input  16  instruction template; bits outside the field pass through.
REQ-009 SHALL have port out_valid  output  1  head entry present.
REQ-010 SHALL have port out_ready  input  1  consumer takes head entry this cycle.
REQ-011 SHALL have port out_word  output  16  encoded instruction word.
REQ-012 SHALL have port out_err  output  1  value was not representable in the selected field.
REQ-013 SHALL have port clr_count  input  1  synchronous clear of err_count.
REQ-014 SHALL have port err_count  output  CNT_W  number of accepted out-of-range requests, saturating.

Function
REQ-015 SHALL map sel to fields: 00 -> bits [7:4], W=4; 01 -> bits [3:0], W=4; 10 -> bits [7:0], W=8; 11 -> bits [11:0], W=12.
REQ-016 SHALL form out_word as base with the selected field replaced by value[W-1:0]; all other bits equal base.
REQ-017 SHALL set out_err=1 when value[15:W-1] are not all equal (not representable as W-bit signed); encoding still uses truncated value[W-1:0].
REQ-018 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1; sel/value/base sampled at that edge only.
REQ-019 SHALL buffer results in a 2-entry FIFO; in_ready=1 exactly when fewer than 2 entries are held (combinational from occupancy only, not from out_ready).
REQ-020 SHALL present an accepted result with out_valid=1 in the cycle after acceptance when the FIFO was empty (latency 1).
REQ-021 SHALL pop the head on a rising edge where out_valid=1 and out_ready=1; out_word/out_err stable while out_valid=1 and out_ready=0.
REQ-022 SHALL preserve acceptance order at the output.
REQ-023 SHALL, on simultaneous push and pop with 1 entry held, keep occupancy 1 with the new entry as head next cycle.
REQ-024 SHALL, with 2 entries held, ignore in_valid (no push) even if a pop occurs that cycle; in_ready returns to 1 the cycle after the pop.
REQ-025 SHALL drive out_word=16'h0000 and out_err=0 whenever out_valid=0.
REQ-026 SHALL increment err_count by 1 at each accepted request with out_err condition true, saturating at 2^CNT_W-1.
REQ-027 SHALL give clr_count priority: clear and erroneous accept in the same cycle yield err_count=0.
REQ-028 SHALL treat in_valid/out_ready with X-free sampling; no other side effects from unaccepted requests.

Reset
REQ-029 SHALL, while rst_n=0, immediately force FIFO empty, out_valid=0, out_word=0, out_err=0, err_count=0, in_ready=1, independent of clk.
REQ-030 SHALL discard all held entries on reset assertion mid-operation; first acceptance possible on the first rising edge with rst_n=1.

Verification
REQ-031 SHALL cover sel=10, value=16'hFFF9, base=16'hA000 -> next cycle out_valid=1, out_word=16'hA0F9, out_err=0.
REQ-032 SHALL cover sel=00, value=16'h0009, base=16'h1234 -> out_word=16'h1294, out_err=1, err_count=1; sel=01, value=16'hFFF8, base=16'h1234 -> 16'h1238, out_err=0.
REQ-033 SHALL cover sel=11, base=16'hF000: value=16'h07FF -> 16'hF7FF err 0; value=16'h0800 -> 16'hF800 err 1.
REQ-034 SHALL cover out_ready=0 with three back-to-back requests -> two accepted, in_ready=0 after second, third held; out_ready=1 -> outputs in acceptance order, third accepted the cycle after first pop.
REQ-035 SHALL cover rst_n pulsed low with 2 entries held and err_count=3 -> out_valid=0, err_count=0, in_ready=1 immediately.
REQ-036 SHALL cover 260 erroneous requests with CNT_W=8 -> err_count=255; then clr_count with an erroneous accept same cycle -> err_count=0.

Source files
------------

// File: rtl/imm_encode_if.sv
// Request/response bundle for imm_encode: request side (in_*) and result side (out_*).
// valid/ready: a transfer happens on a rising edge where valid and ready are both 1; payload must be stable while valid=1.
interface imm_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [15:0] value;
  logic [15:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic        out_err;

  modport master (
    output in_valid, sel, value, base, out_ready,
    input  in_ready, out_valid, out_word, out_err
  );

  modport slave (
    input  in_valid, sel, value, base, out_ready,
    output in_ready, out_valid, out_word, out_err
  );
endinterface

// File: rtl/imm_encode.sv
// Encodes a signed immediate into a selected field of an instruction template,
// buffers results in a 2-entry FIFO and counts out-of-range requests.
module imm_encode #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_encode_if.slave      io,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  logic [15:0] enc_word;
  logic        enc_err;
  logic [15:0] mem_word [2];
  logic        mem_err  [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  // A value fits a W-bit signed field when value[15:W-1] are all equal.
  always_comb begin
    enc_word = io.base;
    enc_err  = 1'b0;
    case (io.sel)
      2'b00: begin
        enc_word = {io.base[15:8], io.value[3:0], io.base[3:0]};
        enc_err  = !((&io.value[15:3]) || !(|io.value[15:3]));
      end
      2'b01: begin
        enc_word = {io.base[15:4], io.value[3:0]};
        enc_err  = !((&io.value[15:3]) || !(|io.value[15:3]));
      end
      2'b10: begin
        enc_word = {io.base[15:8], io.value[7:0]};
        enc_err  = !((&io.value[15:7]) || !(|io.value[15:7]));
      end
      default: begin
        enc_word = {io.base[15:12], io.value[11:0]};
        enc_err  = !((&io.value[15:11]) || !(|io.value[15:11]));
      end
    endcase
  end

  // Readiness depends only on occupancy, so a full FIFO never pushes even when popping.
  assign io.in_ready  = (count != 2'd2);
  assign io.out_valid = (count != 2'd0);
  assign io.out_word  = io.out_valid ? mem_word[rd_ptr] : 16'h0000;
  assign io.out_err   = io.out_valid ? mem_err[rd_ptr]  : 1'b0;

  assign push = (io.in_valid === 1'b1) && io.in_ready;
  assign pop  = (io.out_ready === 1'b1) && io.out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_word[0] <= 16'h0000;
      mem_word[1] <= 16'h0000;
      mem_err[0]  <= 1'b0;
      mem_err[1]  <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        mem_word[wr_ptr] <= enc_word;
        mem_err[wr_ptr]  <= enc_err;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (push && enc_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encode.sv
// Directed bench for imm_encode: field encoding, range errors, FIFO flow control,
// async reset and counter saturation/clear.
module tb_imm_encode;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             clr_count;
  logic [CNT_W-1:0] err_count;
  imm_encode_if     io ();

  int n_checks;
  int n_pass;
  logic [16:0] exp_q[$];

  imm_encode #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io        (io),
    .clr_count (clr_count),
    .err_count (err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: hold the request until accepted, then drop in_valid
  task automatic push_req(input logic [1:0] s, input logic [15:0] v, input logic [15:0] b);
    int n;
    io.in_valid = 1'b1;
    io.sel      = s;
    io.value    = v;
    io.base     = b;
    n = 0;
    while (!io.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!io.in_ready) check("push_timeout", 32'd0, 32'd1);
    tick();
    io.in_valid = 1'b0;
  endtask

  // scoreboard: compare head with the oldest expected entry and pop it
  task automatic pop_chk(input string tag);
    int n;
    logic [16:0] e;
    n = 0;
    while (!io.out_valid && n < 20) begin
      tick();
      n++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0;
    check({tag, "_valid"}, {31'd0, io.out_valid}, 32'd1);
    check({tag, "_word"},  {16'd0, io.out_word}, {16'd0, e[15:0]});
    check({tag, "_err"},   {31'd0, io.out_err},  {31'd0, e[16]});
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    clr_count    = 1'b0;
    io.in_valid  = 1'b0;
    io.sel       = 2'b00;
    io.value     = 16'h0000;
    io.base      = 16'h0000;
    io.out_ready = 1'b0;
    #3;
    check("rst_in_ready",  {31'd0, io.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    check("rst_out_word",  {16'd0, io.out_word}, 32'd0);
    check("rst_out_err",   {31'd0, io.out_err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    #20;
    rst_n = 1'b1;
    tick();

    // sel=10, latency-1 presentation
    exp_q.push_back({1'b0, 16'hA0F9});
    push_req(2'b10, 16'hFFF9, 16'hA000);
    check("lat1_valid", {31'd0, io.out_valid}, 32'd1);
    pop_chk("sel10");
    check("empty_word", {16'd0, io.out_word}, 32'd0);
    check("empty_valid", {31'd0, io.out_valid}, 32'd0);

    // sel=00 out of range, sel=01 in range
    exp_q.push_back({1'b1, 16'h1294});
    push_req(2'b00, 16'h0009, 16'h1234);
    pop_chk("sel00");
    check("cnt_after_sel00", {24'd0, err_count}, 32'd1);
    exp_q.push_back({1'b0, 16'h1238});
    push_req(2'b01, 16'hFFF8, 16'h1234);
    pop_chk("sel01");
    check("cnt_after_sel01", {24'd0, err_count}, 32'd1);

    // sel=11 boundary values
    exp_q.push_back({1'b0, 16'hF7FF});
    push_req(2'b11, 16'h07FF, 16'hF000);
    exp_q.push_back({1'b1, 16'hF800});
    push_req(2'b11, 16'h0800, 16'hF000);
    pop_chk("sel11_max");
    pop_chk("sel11_over");
    check("cnt_after_sel11", {24'd0, err_count}, 32'd2);

    // backpressure: two accepted, third held until the first pop
    exp_q.push_back({1'b0, 16'h0012});
    exp_q.push_back({1'b0, 16'hFFF5});
    exp_q.push_back({1'b0, 16'h0FFF});
    io.in_valid = 1'b1; io.sel = 2'b10; io.value = 16'h0012; io.base = 16'h0000;
    tick();
    io.sel = 2'b01; io.value = 16'h0005; io.base = 16'hFFF0;
    tick();
    check("bp_full_ready", {31'd0, io.in_ready}, 32'd0);
    io.sel = 2'b11; io.value = 16'hFFFF; io.base = 16'h0000;
    tick();
    check("bp_hold_ready", {31'd0, io.in_ready}, 32'd0);
    check("bp_hold_word", {16'd0, io.out_word}, {16'd0, exp_q[0][15:0]});
    io.out_ready = 1'b1;
    tick();
    void'(exp_q.pop_front());
    check("bp_ready_back", {31'd0, io.in_ready}, 32'd1);
    check("bp_second_word", {16'd0, io.out_word}, {16'd0, exp_q[0][15:0]});
    tick();
    void'(exp_q.pop_front());
    io.in_valid = 1'b0;
    check("bp_third_word", {16'd0, io.out_word}, {16'd0, exp_q[0][15:0]});
    check("bp_third_ready", {31'd0, io.in_ready}, 32'd1);
    tick();
    void'(exp_q.pop_front());
    io.out_ready = 1'b0;
    check("bp_drained", {31'd0, io.out_valid}, 32'd0);

    // reset mid-operation with two entries held
    push_req(2'b00, 16'h0010, 16'h0000);
    push_req(2'b01, 16'h0001, 16'h0000);
    check("pre_rst_cnt", {24'd0, err_count}, 32'd3);
    check("pre_rst_ready", {31'd0, io.in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, io.out_valid}, 32'd0);
    check("mid_rst_word",  {16'd0, io.out_word}, 32'd0);
    check("mid_rst_cnt",   {24'd0, err_count}, 32'd0);
    check("mid_rst_ready", {31'd0, io.in_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // saturation: 260 erroneous accepts, one per cycle with continuous draining
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1; io.sel = 2'b00; io.value = 16'h0010; io.base = 16'h0000;
    for (int i = 0; i < 260; i++) begin
      tick();
      if (i == 99) check("sat_mid", {24'd0, err_count}, 32'd100);
    end
    check("sat_max", {24'd0, err_count}, 32'd255);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_priority", {24'd0, err_count}, 32'd0);
    tick();
    check("count_after_clr", {24'd0, err_count}, 32'd1);
    io.in_valid = 1'b0;
    tick();
    tick();
    io.out_ready = 1'b0;
    check("final_empty", {31'd0, io.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
